// File: rtl/conv_window_gen.sv
// -----------------------------------------------------------------------------
// conv_window_gen
//   Streaming sliding-window generator. Pixels arrive one per cycle in raster
//   order; the block keeps KERNEL_LENGTH-1 previous rows in line buffers and a
//   KERNEL_LENGTH x KERNEL_WIDTH shift-register window. For every valid output
//   position (no padding, stride 1) it presents the packed window on map_out
//   through a one-deep registered output stage.
//
// Ports
//   clk          : single clock, rising edge
//   rst          : synchronous active-high reset
//   pixel_in     : input pixel, raster order
//   pixel_valid  : pixel_in valid
//   pixel_ready  : block can accept a pixel this cycle
//   map_out      : packed window, element (r,c) at [DATA_SIZE*(r*KW+c) +: DATA_SIZE]
//   map_valid    : map_out holds a valid window
//   map_ready    : downstream takes map_out this cycle
//   frame_done   : high with map_valid on the last window of a frame
// -----------------------------------------------------------------------------
module conv_window_gen #(
  parameter int DATA_SIZE     = 8,
  parameter int KERNEL_WIDTH  = 3,
  parameter int KERNEL_LENGTH = 3,
  parameter int IMG_WIDTH     = 8,
  parameter int IMG_HEIGHT    = 8
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [DATA_SIZE-1:0]                              pixel_in,
  input  logic                                              pixel_valid,
  output logic                                              pixel_ready,
  output logic [DATA_SIZE*KERNEL_WIDTH*KERNEL_LENGTH-1:0]   map_out,
  output logic                                              map_valid,
  input  logic                                              map_ready,
  output logic                                              frame_done
);

  localparam int MAP_W = DATA_SIZE * KERNEL_WIDTH * KERNEL_LENGTH;
  localparam int CW    = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(KERNEL_WIDTH - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(KERNEL_LENGTH - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  // line_buf[0] holds the most recent previous row, line_buf[KL-2] the oldest.
  logic [DATA_SIZE-1:0] line_buf [0:KERNEL_LENGTH-2][0:IMG_WIDTH-1];
  logic [DATA_SIZE-1:0] win      [0:KERNEL_LENGTH-1][0:KERNEL_WIDTH-1];
  logic [DATA_SIZE-1:0] win_next [0:KERNEL_LENGTH-1][0:KERNEL_WIDTH-1];
  logic [DATA_SIZE-1:0] new_col  [0:KERNEL_LENGTH-1];
  logic [MAP_W-1:0]     win_packed;

  logic accept;
  logic emit;
  logic last_pos;

  // One-deep output register: free whenever it is empty or being drained.
  assign pixel_ready = !map_valid || map_ready;
  assign accept      = pixel_valid && pixel_ready;
  assign emit        = accept && (row >= ROW_FIRST) && (col >= COL_FIRST);
  assign last_pos    = (row == ROW_LAST) && (col == COL_LAST);

  // Column entering the window: stored rows oldest-first on top, live pixel at the bottom.
  always_comb begin
    for (int r = 0; r < KERNEL_LENGTH; r++) begin
      new_col[r] = '0;
    end
    for (int r = 0; r < KERNEL_LENGTH - 1; r++) begin
      new_col[r] = line_buf[KERNEL_LENGTH-2-r][col];
    end
    new_col[KERNEL_LENGTH-1] = pixel_in;
  end

  // Window after this accept: shift left, new column on the right, then pack.
  always_comb begin
    win_packed = '0;
    for (int r = 0; r < KERNEL_LENGTH; r++) begin
      for (int c = 0; c < KERNEL_WIDTH - 1; c++) begin
        win_next[r][c] = win[r][c+1];
      end
      win_next[r][KERNEL_WIDTH-1] = new_col[r];
    end
    for (int r = 0; r < KERNEL_LENGTH; r++) begin
      for (int c = 0; c < KERNEL_WIDTH; c++) begin
        win_packed[DATA_SIZE*(r*KERNEL_WIDTH+c) +: DATA_SIZE] = win_next[r][c];
      end
    end
  end

  // Raster position counters; wrap straight into the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end else begin
      col <= col;
      row <= row;
    end
  end

  // Line buffers and window shift registers; contents are don't-care after reset
  // because row/column gating keeps stale data out of emitted windows.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_buf[0][col] <= pixel_in;
      for (int k = 1; k < KERNEL_LENGTH - 1; k++) begin
        line_buf[k][col] <= line_buf[k-1][col];
      end
      for (int r = 0; r < KERNEL_LENGTH; r++) begin
        for (int c = 0; c < KERNEL_WIDTH; c++) begin
          win[r][c] <= win_next[r][c];
        end
      end
    end
  end

  // Output register: load on an emitting accept, drop valid once drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      map_out    <= '0;
      map_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else if (emit) begin
      map_out    <= win_packed;
      map_valid  <= 1'b1;
      frame_done <= last_pos;
    end else if (map_valid && map_ready) begin
      map_out    <= map_out;
      map_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      map_out    <= map_out;
      map_valid  <= map_valid;
      frame_done <= frame_done;
    end
  end

endmodule
